run_controller: RTL and testbench

- Sequences execution of the nic8 CPU core: gates the core's clock enable for run, halt and single-step.
- Owns the shared 8-bit bus and the data RAM while the core is halted, so an external byte-stream loader can deposit a program.
- Issues a CPU restart once a load completes.
- Sits between the front panel/host link and the core; the core's instruction decoder is unchanged and simply sees `cpu_en` low while halted.

---
 rtl/nic8_pkg.sv | 16 +
 rtl/load_addr_counter.sv | 36 +++
 rtl/run_controller.sv | 143 ++++++++++++++
 tb/tb_run_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nic8_pkg.sv
// Shared types and defaults for the nic8 run controller: FSM state encoding
// (also the panel LED code), default address width and halt opcode.
package nic8_pkg;

  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_LOAD = 3'd3,
    ST_BOOT = 3'd4
  } state_e;

  localparam int         ADDR_W_DEF  = 8;
  localparam logic [7:0] HALT_OP_DEF = 8'h00;

endpackage

// File: rtl/load_addr_counter.sv
// Wrapping W-bit counter; clr reloads INIT, en steps by one (down when DOWN=1).
// Registered output, one-cycle update latency, no backpressure.
module load_addr_counter #(
  parameter int         W    = 8,
  parameter bit         DOWN = 1'b0,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = INIT;
    end else if (en) begin
      cnt_d = DOWN ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_controller.sv
// nic8 run/halt/step sequencer and program loader; outputs decode from the state register,
// loader handshake is ld_ready=1 throughout LOAD. Breakpoint option: RUN_CONTROLLER_BREAKPOINT_EN.
module run_controller
  import nic8_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [7:0] HALT_OP     = HALT_OP_DEF,
  parameter int         BOOT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [7:0]        ir,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic              bus_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic [2:0]        state
`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  ,
  input  logic              bp_set,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_clear
`endif
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   boot_cnt;
  logic            xfer;
  logic            bp_hit;

  assign xfer = (state_q == ST_LOAD) && ld_valid;

  // Address restarts at 0 on every entry to LOAD because it is held clear elsewhere.
  load_addr_counter #(.W(ADDR_W), .DOWN(1'b0), .INIT('0)) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_LOAD),
    .en    (xfer),
    .cnt   (mem_addr)
  );

  load_addr_counter #(.W(BW), .DOWN(1'b1), .INIT(BW'(BOOT_CYCLES - 1))) u_boot_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_BOOT),
    .en    ((state_q == ST_BOOT) && (boot_cnt != '0)),
    .cnt   (boot_cnt)
  );

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  logic              bp_armed_q, bp_armed_d;
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;

  always_comb begin
    bp_armed_d = bp_armed_q;
    bp_addr_d  = bp_addr_q;
    if (bp_set) begin
      bp_armed_d = 1'b1;
      bp_addr_d  = bp_addr;
    end
    if (bp_clear) begin
      bp_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_armed_q <= 1'b0;
      bp_addr_q  <= '0;
    end else begin
      bp_armed_q <= bp_armed_d;
      bp_addr_q  <= bp_addr_d;
    end
  end

  assign bp_hit = bp_armed_q && (pc == bp_addr_q);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cpu_en    = 1'b0;
    cpu_rst   = 1'b0;
    bus_grant = 1'b0;
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        cpu_rst = 1'b1;
        if (boot_cnt == '0) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (step_req)      state_d = ST_STEP;
        else if (run_req)  state_d = ST_RUN;
        else if (ld_valid) state_d = ST_LOAD;
      end
      ST_RUN: begin
        // A breakpoint suppresses the instruction at pc, so the halt opcode cannot fire with it.
        cpu_en = !bp_hit;
        if (halt_req || bp_hit || (ir == HALT_OP)) state_d = ST_HALT;
      end
      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALT;
      end
      ST_LOAD: begin
        bus_grant = 1'b1;
        ld_ready  = 1'b1;
        mem_we    = ld_valid;
        if (ld_valid && ld_last) state_d = ST_BOOT;
        else if (halt_req)       state_d = ST_HALT;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_wdata = ld_data;
  assign state     = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: an 8-bit-address instance drives a small core/RAM model,
// a 4-bit-address instance shares the same stimulus to exercise loader address wrap.
module tb_run_controller;

  logic       clk;
  logic       reset;
  logic       run_req, halt_req, step_req;
  logic [7:0] ir;
  logic [7:0] pc;
  logic       ld_valid, ld_last;
  logic [7:0] ld_data;

  logic       ld_ready, cpu_en, cpu_rst, bus_grant, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [2:0] state;

  logic       ld_ready_4, cpu_en_4, cpu_rst_4, bus_grant_4, mem_we_4;
  logic [3:0] mem_addr_4;
  logic [7:0] mem_wdata_4;
  logic [2:0] state_4;

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  logic       bp_set, bp_clear;
  logic [7:0] bp_addr;
`endif

  int passes = 0;
  int total  = 0;
  logic [7:0] pgm [0:31];
  logic [7:0] ram [0:255];

  run_controller #(.ADDR_W(8)) u8 (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .ir(ir), .pc(pc), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_en(cpu_en), .cpu_rst(cpu_rst), .bus_grant(bus_grant),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .state(state)
`ifdef RUN_CONTROLLER_BREAKPOINT_EN
    , .bp_set(bp_set), .bp_addr(bp_addr), .bp_clear(bp_clear)
`endif
  );

  run_controller #(.ADDR_W(4)) u4 (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .ir(ir), .pc(pc[3:0]), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_4), .cpu_en(cpu_en_4), .cpu_rst(cpu_rst_4), .bus_grant(bus_grant_4),
    .mem_addr(mem_addr_4), .mem_we(mem_we_4), .mem_wdata(mem_wdata_4), .state(state_4)
`ifdef RUN_CONTROLLER_BREAKPOINT_EN
    , .bp_set(bp_set), .bp_addr(bp_addr[3:0]), .bp_clear(bp_clear)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Minimal core model: pc advances once per enabled cycle, ir reads the RAM at pc.
  always @(posedge clk) begin
    if (cpu_rst) pc <= 8'h00;
    else if (cpu_en) pc <= pc + 8'h01;
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign ir = ram[pc];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Loads pgm[0..n-1] starting from HALT, then checks the BOOT/HALT return.
  task automatic load_pgm(input int n, input bit gap);
    ld_valid = 1'b1; ld_data = pgm[0]; ld_last = (n == 1);
    #1;
    chk("ld_halt_ready", 32'(ld_ready), 0);
    chk("ld_halt_we", 32'(mem_we), 0);
    cyc();
    for (int i = 0; i < n; i++) begin
      if (gap && i == 1) begin
        ld_valid = 1'b0;
        #1;
        chk("ld_gap_we", 32'(mem_we), 0);
        chk("ld_gap_addr", 32'(mem_addr), 1);
        cyc();
        ld_valid = 1'b1;
      end
      ld_data = pgm[i]; ld_last = (i == n - 1);
      #1;
      chk("ld_we", 32'(mem_we), 1);
      chk("ld_grant", 32'(bus_grant), 1);
      chk("ld_addr", 32'(mem_addr), 32'(i[7:0]));
      chk("ld_addr4", 32'(mem_addr_4), 32'(i[3:0]));
      chk("ld_wdata", 32'(mem_wdata), 32'(pgm[i]));
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    chk("ld_boot_state", 32'(state), 4);
    chk("ld_boot_grant", 32'(bus_grant), 0);
    chk("ld_boot_rst", 32'(cpu_rst), 1);
    cyc();
    chk("ld_boot2_state", 32'(state), 4);
    cyc();
    chk("ld_halt_state", 32'(state), 0);
    chk("ld_halt_rst", 32'(cpu_rst), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
`ifdef RUN_CONTROLLER_BREAKPOINT_EN
    bp_set = 1'b0; bp_clear = 1'b0; bp_addr = 8'h00;
`endif
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 4);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_grant", 32'(bus_grant), 0);
    chk("rst_ready", 32'(ld_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_rst) n++;
      cyc();
    end
    chk("boot_width", 32'(n), 2);
    chk("idle_state", 32'(state), 0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_en_grant", 32'({cpu_en, bus_grant}), 0);
      cyc();
    end

    // Three-byte load with a gap after the first byte
    pgm[0] = 8'hA1; pgm[1] = 8'hB2; pgm[2] = 8'hC3;
    load_pgm(3, 1'b1);

    // Program 12, 34, HALT_OP then free-run
    pgm[0] = 8'h12; pgm[1] = 8'h34; pgm[2] = 8'h00;
    load_pgm(3, 1'b0);
    chk("run_pc0", 32'(pc), 0);
    run_req = 1'b1;
    #1;
    chk("run_req_en", 32'(cpu_en), 0);
    cyc();
    run_req = 1'b0;
    #1;
    chk("run1_state", 32'(state), 1);
    chk("run1_en", 32'(cpu_en), 1);
    chk("run1_ir", 32'(ir), 'h12);
    cyc();
    chk("run2_en", 32'(cpu_en), 1);
    chk("run2_ir", 32'(ir), 'h34);
    cyc();
    chk("run3_en", 32'(cpu_en), 1);
    chk("run3_ir", 32'(ir), 'h00);
    cyc();
    chk("run_end_state", 32'(state), 0);
    chk("run_end_en", 32'(cpu_en), 0);
    chk("run_end_pc", 32'(pc), 3);

    // Two single steps; the request held into STEP is dropped
    step_req = 1'b1;
    #1;
    chk("step_req_en", 32'(cpu_en), 0);
    cyc();
    chk("step1_state", 32'(state), 2);
    chk("step1_en", 32'(cpu_en), 1);
    cyc();
    step_req = 1'b0;
    #1;
    chk("step1_done_state", 32'(state), 0);
    for (int i = 0; i < 5; i++) begin
      chk("step_gap_en", 32'(cpu_en), 0);
      cyc();
    end
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    #1;
    chk("step2_state", 32'(state), 2);
    chk("step2_en", 32'(cpu_en), 1);
    cyc();
    chk("step2_done_state", 32'(state), 0);
    cyc(); cyc(); cyc();
    chk("step_pc", 32'(pc), 5);

    // 17-byte load: the 4-bit instance wraps the last byte to address 0
    for (int i = 0; i < 17; i++) pgm[i] = 8'(i + 1);
    load_pgm(17, 1'b0);

    // Run with halt_req; ld_valid ignored while running
    run_req = 1'b1; ld_valid = 1'b1; ld_data = 8'h55;
    cyc();
    run_req = 1'b0;
    #1;
    chk("runh1_state", 32'(state), 1);
    chk("runh1_en", 32'(cpu_en), 1);
    chk("runh1_ready", 32'(ld_ready), 0);
    chk("runh1_we", 32'(mem_we), 0);
    cyc();
    halt_req = 1'b1; ld_valid = 1'b0;
    #1;
    chk("runh2_en", 32'(cpu_en), 1);
    cyc();
    halt_req = 1'b0;
    #1;
    chk("runh_end_state", 32'(state), 0);
    chk("runh_end_en", 32'(cpu_en), 0);
    chk("runh_end_pc", 32'(pc), 2);

    // Reset in the middle of a load
    ld_valid = 1'b1; ld_data = 8'h77;
    cyc();
    chk("lrst_we0", 32'(mem_we), 1);
    chk("lrst_addr0", 32'(mem_addr), 0);
    cyc();
    chk("lrst_addr1", 32'(mem_addr), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("lrst_state", 32'(state), 4);
    chk("lrst_we", 32'(mem_we), 0);
    chk("lrst_addr", 32'(mem_addr), 0);
    chk("lrst_grant", 32'(bus_grant), 0);
    cyc();
    chk("lrst_boot2_state", 32'(state), 4);
    chk("lrst_boot2_we", 32'(mem_we), 0);
    ld_valid = 1'b0;
    cyc();
    chk("lrst_halt_state", 32'(state), 0);
    chk("lrst_halt_we", 32'(mem_we), 0);

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
    bp_addr = 8'h05; bp_set = 1'b1;
    cyc();
    bp_set = 1'b0; run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_run_en", 32'(cpu_en), 1);
      cyc();
    end
    #1;
    chk("bp_hit_pc", 32'(pc), 5);
    chk("bp_hit_en", 32'(cpu_en), 0);
    cyc();
    chk("bp_halt_state", 32'(state), 0);
    chk("bp_halt_pc", 32'(pc), 5);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    #1;
    chk("bp_step_en", 32'(cpu_en), 1);
    cyc();
    chk("bp_step_pc", 32'(pc), 6);
    chk("bp_step_state", 32'(state), 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
